// File: rtl/cmp_flag_gen_if.sv
// Operand/flag handshake bundle for cmp_flag_gen: operand pair in, N/C/V/Z flags out.
interface cmp_flag_gen_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flag_valid;
  logic             flag_ready;
  logic             FlagN;
  logic             FlagC;
  logic             FlagV;
  logic             FlagZ;

  modport master (
    output start_valid, a, b, flag_ready,
    input  start_ready, flag_valid, FlagN, FlagC, FlagV, FlagZ
  );

  modport slave (
    input  start_valid, a, b, flag_ready,
    output start_ready, flag_valid, FlagN, FlagC, FlagV, FlagZ
  );
endinterface

// File: rtl/cmp_flag_gen.sv
// Digit-serial A-B flag generator (N/C/V, plus Z when CMP_FLAG_Z_EN is defined).
// WIDTH must be a multiple of DIGIT; one DIGIT-wide slice is subtracted per cycle.
module cmp_flag_gen #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_flag_gen_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic                   carry_q, carry_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   start_ready_q, start_ready_d;
  logic                   flag_valid_q, flag_valid_d;
  logic                   n_q, n_d, c_q, c_d, v_q, v_d;
  logic [DIGIT:0]         digit_sum;
  logic [WIDTH+DIGIT-1:0] res_ext;
  logic                   last_digit;
`ifdef CMP_FLAG_Z_EN
  logic                   zacc_q, zacc_d, z_q, z_d;
`endif

  always_comb begin
    digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    res_ext    = {digit_sum[DIGIT-1:0], res_q};
    last_digit = (cnt_q == CW'(NDIG - 1));

    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    carry_d       = carry_q;
    cnt_d         = cnt_q;
    start_ready_d = start_ready_q;
    flag_valid_d  = flag_valid_q;
    n_d           = n_q;
    c_d           = c_q;
    v_d           = v_q;
`ifdef CMP_FLAG_Z_EN
    zacc_d        = zacc_q;
    z_d           = z_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d           = bus.a;
          b_d           = bus.b;
          carry_d       = 1'b1;
          cnt_d         = '0;
          start_ready_d = 1'b0;
          state_d       = RUN;
`ifdef CMP_FLAG_Z_EN
          zacc_d        = 1'b0;
`endif
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_ext[WIDTH+DIGIT-1:DIGIT];
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
`ifdef CMP_FLAG_Z_EN
        zacc_d  = zacc_q | (|digit_sum[DIGIT-1:0]);
`endif
        if (last_digit) begin
          // The operand top digits now sit in the low slice, so their MSBs are the sign bits.
          n_d          = digit_sum[DIGIT-1];
          c_d          = digit_sum[DIGIT];
          v_d          = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (digit_sum[DIGIT-1] != a_q[DIGIT-1]);
`ifdef CMP_FLAG_Z_EN
          z_d          = ~(zacc_q | (|digit_sum[DIGIT-1:0]));
`endif
          flag_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.flag_ready) begin
          flag_valid_d  = 1'b0;
          start_ready_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d       = IDLE;
        start_ready_d = 1'b1;
        flag_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      carry_q       <= 1'b0;
      cnt_q         <= '0;
      start_ready_q <= 1'b1;
      flag_valid_q  <= 1'b0;
      n_q           <= 1'b0;
      c_q           <= 1'b0;
      v_q           <= 1'b0;
`ifdef CMP_FLAG_Z_EN
      zacc_q        <= 1'b0;
      z_q           <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      carry_q       <= carry_d;
      cnt_q         <= cnt_d;
      start_ready_q <= start_ready_d;
      flag_valid_q  <= flag_valid_d;
      n_q           <= n_d;
      c_q           <= c_d;
      v_q           <= v_d;
`ifdef CMP_FLAG_Z_EN
      zacc_q        <= zacc_d;
      z_q           <= z_d;
`endif
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.flag_valid  = flag_valid_q;
  assign bus.FlagN       = n_q;
  assign bus.FlagC       = c_q;
  assign bus.FlagV       = v_q;
`ifdef CMP_FLAG_Z_EN
  assign bus.FlagZ       = z_q;
`else
  assign bus.FlagZ       = 1'b0;
`endif
endmodule

// File: doc/cmp_flag_gen.md
# cmp_flag_gen

Multi-cycle flag generator that computes A − B digit-serially and produces the N/C/V (and optionally Z) condition flags consumed by the downstream signed/unsigned less-than comparator. It sits between the Mandelbrot iteration datapath, which supplies operand pairs for the escape-radius and loop-bound tests, and the comparator. It trades latency for a narrow adder so wide operands do not need a full-width carry chain.

## Interface
- WIDTH, 32, operand width in bits; must be an integer multiple of DIGIT.
- DIGIT, 8, bits subtracted per cycle; 1 ≤ DIGIT ≤ WIDTH.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start_valid  input  1  operand pair on a/b is valid.
- start_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  minuend; sampled only on the accept edge.
- b  input  WIDTH  subtrahend; sampled only on the accept edge.
- flag_valid  output  1  flags below are valid.
- flag_ready  input  1  consumer takes the flags.
- FlagN  output  1  MSB of A − B.
- FlagC  output  1  carry out of A + ~B + 1 (1 = no borrow, A ≥ B unsigned).
- FlagV  output  1  two's-complement overflow of A − B.
- FlagZ  output  1  A − B == 0 (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready = 1. On start_valid & start_ready: latch a, b into shift registers; carry ← 1; digit counter ← 0; zero-accumulator ← 0; → RUN.
- RUN: start_ready = 0. Each cycle, add the lowest DIGIT bits of A and ~B plus carry, LSB digit first; shift both operands right by DIGIT; store the sum digit into the result shift register; carry ← digit carry-out; OR the sum digit into the zero-accumulator; counter +1. On the cycle processing digit WIDTH/DIGIT−1, register flags and → DONE.
- Flag rules, evaluated on the final WIDTH-bit result R: FlagN = R[WIDTH−1]; FlagC = final carry-out; FlagV = (A[WIDTH−1] ≠ B[WIDTH−1]) & (R[WIDTH−1] ≠ A[WIDTH−1]); FlagZ = ~(zero-accumulator).
- DONE: flag_valid = 1; flags held stable. On flag_valid & flag_ready → IDLE; flag_valid deasserts the following cycle.
- start_valid is ignored outside IDLE; a and b may change freely after the accept edge.
- Reset (rst_n = 0 at an edge) in any state: → IDLE, discard partial result. Reset values: start_ready = 1 (from the first edge after release... and during reset asserted, since state is IDLE), flag_valid = 0, FlagN = FlagC = FlagV = FlagZ = 0.

## Timing
- Accept edge = edge 0. Digits processed at edges 1..WIDTH/DIGIT. flag_valid high immediately after edge WIDTH/DIGIT (4 cycles for defaults).
- Flag handshake edge h → start_ready high after edge h; next accept at earliest h+1.
- Minimum period between accepts: WIDTH/DIGIT + 2 cycles.
- No combinational path from inputs to outputs; all outputs registered or state-decoded.
- flag_ready held low: flags and flag_valid remain constant indefinitely.

## Configuration
- CMP_FLAG_Z_EN defined: zero-accumulator present; FlagZ as specified.
- CMP_FLAG_Z_EN undefined: accumulator removed; FlagZ port retained and tied to 0 in all states. N/C/V behaviour and timing unchanged.

## Test plan
- a=5, b=3 (defaults) -> flag_valid 4 cycles after accept; N=0, C=1, V=0, Z=0.
- a=3, b=5 -> R=0xFFFFFFFE; N=1, C=0, V=0, Z=0.
- a=0x80000000, b=1 -> R=0x7FFFFFFF; N=0, C=1, V=1, Z=0 (N^V=1: signed less-than holds).
- a=b=0x00001234 -> N=0, C=1, V=0, Z=1 with CMP_FLAG_Z_EN; Z=0 without.
- flag_ready low 5 cycles while start_valid pulses with new operands -> flags unchanged, start_ready 0, new operands not accepted; after flag_ready, start_ready high next cycle and next pair accepted.
- rst_n low for one edge at second RUN cycle -> next cycle start_ready=1, flag_valid=0, all flags 0; fresh compare a=7, b=7 then completes normally.
